// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM states and request kinds.
// Imported by mem_responder.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      FETCH,
      READ,
      WRITE
   } kind_t;

endpackage

// File: rtl/mem_responder.sv
// Bridges 16-bit CPU fetch/read/write requests onto an 8-bit external bus,
// one byte phase per lane with WAIT extra cycles per phase.
// Ports: clk, reset (sync, active-low); pc/ifetch, addr/rstrobe/wmask/wdata/
//   io_access from the CPU; idone/rdone/wdone/rdata back to it;
//   ext_addr/ext_wdata/ext_rdata/ext_oe_n/ext_we_n/ext_io to the bus.
module mem_responder
   import mem_pkg::*;
#(
   parameter int RV   = 16,
   parameter int VA   = 16,
   parameter int WAIT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [VA-1:1] pc,
   input  logic          ifetch,
   input  logic [VA-1:1] addr,
   input  logic [1:0]    rstrobe,
   input  logic [1:0]    wmask,
   input  logic [RV-1:0] wdata,
   input  logic          io_access,
   output logic          idone,
   output logic          rdone,
   output logic          wdone,
   output logic [RV-1:0] rdata,
   output logic [VA-1:0] ext_addr,
   output logic [7:0]    ext_wdata,
   input  logic [7:0]    ext_rdata,
   output logic          ext_oe_n,
   output logic          ext_we_n,
   output logic          ext_io
);

   localparam logic [2:0] WCNT = 3'(WAIT);

   state_t        state;
   kind_t         kind;
   logic [VA-2:0] hw;
   logic [1:0]    lanes;
   logic          lane;
   logic [7:0]    wd_hi;
   logic [2:0]    cnt;
   logic [7:0]    lo;

   kind_t         req_kind;
   logic [1:0]    req_lanes;
   logic [VA-2:0] req_hw;
   logic          req;
   logic          first;

   // Request arbitration: write beats read beats fetch.
   always_comb begin
      req_kind  = FETCH;
      req_lanes = 2'b11;
      req_hw    = pc;
      if (wmask != 2'b00) begin
         req_kind  = WRITE;
         req_lanes = wmask;
         req_hw    = addr;
      end else if (rstrobe != 2'b00) begin
         req_kind  = READ;
         req_lanes = rstrobe;
         req_hw    = addr;
      end
   end

   assign req   = (wmask != 2'b00) | (rstrobe != 2'b00) | ifetch;
   // Even lane goes first whenever it is requested.
   assign first = ~req_lanes[0];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         kind      <= FETCH;
         hw        <= '0;
         lanes     <= 2'b00;
         lane      <= 1'b0;
         wd_hi     <= 8'h00;
         cnt       <= 3'd0;
         lo        <= 8'h00;
         idone     <= 1'b0;
         rdone     <= 1'b0;
         wdone     <= 1'b0;
         rdata     <= '0;
         ext_addr  <= '0;
         ext_wdata <= 8'h00;
         ext_oe_n  <= 1'b1;
         ext_we_n  <= 1'b1;
         ext_io    <= 1'b0;
      end else begin
         idone <= 1'b0;
         rdone <= 1'b0;
         wdone <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req) begin
                  kind      <= req_kind;
                  hw        <= req_hw;
                  lanes     <= req_lanes;
                  lane      <= first;
                  wd_hi     <= wdata[15:8];
                  cnt       <= WCNT;
                  ext_addr  <= {req_hw, first};
                  ext_oe_n  <= (req_kind == WRITE);
                  ext_we_n  <= (req_kind != WRITE);
                  ext_io    <= (req_kind != FETCH) & io_access;
                  ext_wdata <= (req_kind != WRITE) ? 8'h00 :
                               first ? wdata[15:8] : wdata[7:0];
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt != 3'd0) begin
                  cnt <= cnt - 3'd1;
               end else if (!lane && lanes[1]) begin
                  // Even byte done, odd byte follows.
                  lo        <= ext_rdata;
                  lane      <= 1'b1;
                  cnt       <= WCNT;
                  ext_addr  <= {hw, 1'b1};
                  ext_wdata <= (kind == WRITE) ? wd_hi : 8'h00;
               end else begin
                  // Last phase: finish the bus cycle and report.
                  if (kind != WRITE) begin
                     // A lone byte is mirrored into both halves.
                     rdata <= (lanes == 2'b11) ? {ext_rdata, lo}
                                               : {ext_rdata, ext_rdata};
                  end
                  idone     <= (kind == FETCH);
                  rdone     <= (kind == READ);
                  wdone     <= (kind == WRITE);
                  ext_oe_n  <= 1'b1;
                  ext_we_n  <= 1'b1;
                  ext_io    <= 1'b0;
                  ext_wdata <= 8'h00;
                  state     <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder with a behavioural byte memory
// on the external bus and randomized fetch/read/write traffic.
module tb_mem_responder;

   localparam int VA = 16;
   localparam int W  = 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [VA-1:1] pc = '0;
   logic          ifetch = 1'b0;
   logic [VA-1:1] addr = '0;
   logic [1:0]    rstrobe = 2'b00;
   logic [1:0]    wmask = 2'b00;
   logic [15:0]   wdata = 16'h0000;
   logic          io_access = 1'b0;
   logic          idone, rdone, wdone;
   logic [15:0]   rdata;
   logic [VA-1:0] ext_addr;
   logic [7:0]    ext_wdata;
   logic [7:0]    ext_rdata;
   logic          ext_oe_n, ext_we_n, ext_io;

   mem_responder #(.RV(16), .VA(VA), .WAIT(W)) dut (
      .clk(clk), .reset(reset),
      .pc(pc), .ifetch(ifetch),
      .addr(addr), .rstrobe(rstrobe), .wmask(wmask),
      .wdata(wdata), .io_access(io_access),
      .idone(idone), .rdone(rdone), .wdone(wdone),
      .rdata(rdata),
      .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_rdata(ext_rdata),
      .ext_oe_n(ext_oe_n), .ext_we_n(ext_we_n),
      .ext_io(ext_io)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:65535];
   assign ext_rdata = mem[ext_addr];
   always @(posedge clk)
      if (reset && !ext_we_n) mem[ext_addr] <= ext_wdata;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] exp_rdata = 16'h0000;

   task automatic drop_inputs();
      ifetch = 1'b0;
      rstrobe = 2'b00;
      wmask = 2'b00;
   endtask

   // Called just after a falling edge; returns just after a falling edge.
   task automatic run_txn(input logic [VA-1:1] t_pc, input logic t_if,
                          input logic [VA-1:1] t_addr,
                          input logic [1:0] t_rs, input logic [1:0] t_wm,
                          input logic [15:0] t_wd, input logic t_io,
                          input bit scramble);
      int kind, p, d, got, bad, ph;
      logic [1:0] ls;
      logic [VA-1:1] hw;
      logic [VA-1:0] b0;
      logic [7:0] m0, m1;
      logic ln;
      logic [2:0] exp_v, got_v;
      logic [15:0] got_rd;
      kind = (t_wm != 0) ? 2 : (t_rs != 0) ? 1 : 0;
      ls = (kind == 2) ? t_wm : (kind == 1) ? t_rs : 2'b11;
      hw = (kind == 0) ? t_pc : t_addr;
      p = int'(ls[0]) + int'(ls[1]);
      d = 1 + p * (W + 1);
      b0 = {hw, 1'b0};
      m0 = mem[b0];
      m1 = mem[b0 + 1];
      exp_v = (kind == 0) ? 3'b100 : (kind == 1) ? 3'b010 : 3'b001;
      if (kind != 2)
         exp_rdata = (ls == 2'b11) ? {m1, m0} :
                     (ls == 2'b01) ? {m0, m0} : {m1, m1};
      pc = t_pc; ifetch = t_if; addr = t_addr; rstrobe = t_rs;
      wmask = t_wm; wdata = t_wd; io_access = t_io;
      @(posedge clk);
      got = 0; bad = 0; got_v = 3'b000; got_rd = 16'h0;
      for (int c = 1; c <= d + 4 && got == 0; c++) begin
         @(negedge clk);
         if (idone | rdone | wdone) begin
            got = c;
            got_v = {idone, rdone, wdone};
            got_rd = rdata;
         end else if (c < d) begin
            ph = (c - 1) / (W + 1);
            ln = (p == 2) ? (ph == 1) : ls[1];
            if (ext_addr !== {hw, ln}) bad++;
            if (ext_oe_n !== (kind == 2)) bad++;
            if (ext_we_n !== (kind != 2)) bad++;
            if (ext_io !== ((kind != 0) && t_io)) bad++;
            if (kind == 2 && ext_wdata !== (ln ? t_wd[15:8] : t_wd[7:0]))
               bad++;
            if (bad != 0 && c < d && got == 0 && ph >= 0) begin end
         end
         if (scramble && c == 1) begin
            pc = VA'($urandom) >> 1; addr = VA'($urandom) >> 1;
            wdata = 16'($urandom); io_access = 1'($urandom);
            rstrobe = 2'($urandom); wmask = 2'($urandom);
            ifetch = 1'($urandom);
         end
      end
      n_cmp++;
      if (got != d) begin
         n_err++;
         $display("FAIL latency: kind %0d lanes %b done at cycle %0d, want %0d",
                  kind, ls, got, d);
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL phase: kind %0d hw %h lanes %b had %0d bad signal samples, want 0",
                  kind, hw, ls, bad);
      end
      n_cmp++;
      if (got_v !== exp_v) begin
         n_err++;
         $display("FAIL pulse: {i,r,w}done=%b, want %b", got_v, exp_v);
      end
      n_cmp++;
      if (got_rd !== exp_rdata) begin
         n_err++;
         $display("FAIL rdata: kind %0d got %h, want %h", kind, got_rd, exp_rdata);
      end
      if (kind == 2) begin
         n_cmp++;
         if (mem[b0] !== (ls[0] ? t_wd[7:0] : m0) ||
             mem[b0 + 1] !== (ls[1] ? t_wd[15:8] : m1)) begin
            n_err++;
            $display("FAIL memwrite: at %h got %h%h, want %h%h", b0,
                     mem[b0 + 1], mem[b0],
                     ls[1] ? t_wd[15:8] : m1, ls[0] ? t_wd[7:0] : m0);
         end
      end
      if (got != 0) begin
         @(negedge clk);
         n_cmp++;
         if ({idone, rdone, wdone} !== 3'b000 || ext_oe_n !== 1'b1 ||
             ext_we_n !== 1'b1 || ext_io !== 1'b0 || rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL after_done: done=%b oe_n=%b we_n=%b io=%b rdata=%h, want 000 1 1 0 %h",
                     {idone, rdone, wdone}, ext_oe_n, ext_we_n, ext_io,
                     rdata, exp_rdata);
         end
      end
      drop_inputs();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drop_inputs();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({idone, rdone, wdone} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_done: got %b, want 000", {idone, rdone, wdone});
      end
      n_cmp++;
      if (rdata !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_rdata: got %h, want 0000", rdata);
      end
      n_cmp++;
      if (ext_oe_n !== 1'b1 || ext_we_n !== 1'b1 || ext_io !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctl: oe_n=%b we_n=%b io=%b, want 1 1 0",
                  ext_oe_n, ext_we_n, ext_io);
      end
      n_cmp++;
      if (ext_addr !== 16'h0000 || ext_wdata !== 8'h00) begin
         n_err++;
         $display("FAIL reset_bus: addr=%h wdata=%h, want 0000 00",
                  ext_addr, ext_wdata);
      end
      exp_rdata = 16'h0000;
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fetch_word();
      mem[16'h0020] = 8'h34;
      mem[16'h0021] = 8'h12;
      run_txn(15'h0010, 1'b1, 15'h0, 2'b00, 2'b00, 16'h0, 1'b1, 1'b0);
      n_cmp++;
      if (exp_rdata !== 16'h1234 || rdata !== 16'h1234) begin
         n_err++;
         $display("FAIL fetch_word: rdata %h, want 1234", rdata);
      end
   endtask

   task automatic test_byte_write();
      mem[16'h0100] = 8'h3C;
      mem[16'h0101] = 8'h00;
      run_txn(15'h0, 1'b0, 15'h0080, 2'b00, 2'b10, 16'hA5A5, 1'b0, 1'b0);
      n_cmp++;
      if (mem[16'h0101] !== 8'hA5 || mem[16'h0100] !== 8'h3C) begin
         n_err++;
         $display("FAIL byte_write: mem[101:100]=%h%h, want A53C",
                  mem[16'h0101], mem[16'h0100]);
      end
   endtask

   task automatic test_odd_read_io();
      mem[16'h0401] = 8'h80;
      run_txn(15'h0, 1'b0, 15'h0200, 2'b10, 2'b00, 16'h0, 1'b1, 1'b0);
      n_cmp++;
      if (rdata !== 16'h8080) begin
         n_err++;
         $display("FAIL odd_read: rdata %h, want 8080", rdata);
      end
   endtask

   task automatic test_priority();
      run_txn(15'h0123, 1'b1, 15'h0456, 2'b11, 2'b11, 16'hBEEF, 1'b0, 1'b0);
      run_txn(15'h0123, 1'b1, 15'h0456, 2'b00, 2'b00, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      pc = '0; ifetch = 1'b0; addr = 15'h0777; rstrobe = 2'b00;
      wmask = 2'b11; wdata = 16'hC33C; io_access = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ext_we_n !== 1'b1 || wdone !== 1'b0 || ext_io !== 1'b0 ||
          ext_addr !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_mid: we_n=%b wdone=%b io=%b addr=%h, want 1 0 0 0000",
                  ext_we_n, wdone, ext_io, ext_addr);
      end
      exp_rdata = 16'h0000;
      reset = 1'b1;
      run_txn(15'h0, 1'b0, 15'h0777, 2'b00, 2'b11, 16'hC33C, 1'b1, 1'b0);
   endtask

   task automatic test_random(input int n);
      logic [1:0] rs, wm;
      logic f;
      for (int i = 0; i < n; i++) begin
         wm = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
         rs = 2'($urandom);
         f = 1'($urandom);
         if (wm == 0 && rs == 0) f = 1'b1;
         run_txn(15'($urandom), f, 15'($urandom), rs, wm, 16'($urandom),
                 1'($urandom), ($urandom_range(0, 3) == 0));
      end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      @(negedge clk);
      test_reset();
      test_fetch_word();
      test_byte_write();
      test_odd_read_io();
      test_priority();
      test_reset_mid();
      test_random(60);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
